// File: rtl/flit_injector.sv
// flit_injector: local-PE injection FIFO that XY-routes each head flit into the first free
// deflection channel (N, S, E, W) and registers all four channels through one stage.
module flit_injector #(
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [2:0] NODE_ROW     = 3'd4,
  parameter logic [2:0] NODE_COL     = 3'd4,
  parameter int         STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] loc_flit,
  input  logic        loc_valid,
  output logic        loc_ready,
  input  logic [10:0] northad,
  input  logic [10:0] southad,
  input  logic [10:0] eastad,
  input  logic [10:0] westad,
  input  logic        nvalid_i,
  input  logic        svalid_i,
  input  logic        evalid_i,
  input  logic        wvalid_i,
  output logic [10:0] nad,
  output logic [10:0] sad,
  output logic [10:0] ead,
  output logic [10:0] wad,
  output logic        nvalid_o,
  output logic        svalid_o,
  output logic        evalid_o,
  output logic        wvalid_o,
  output logic        starve,
  output logic        inj_fire
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, ACTIVE, STARVED} state_t;
  state_t state_q, state_d;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q, count_d;
  logic [BW-1:0] blocked_q, blocked_d;
  logic [3:0][10:0] ch_in, ch_q, ch_d;
  logic [3:0] v_in, v_q, v_d, free, sel;
  logic [7:0] head;
  logic [10:0] inj_flit;
  logic [2:0] row, col, dir;
  logic push, pop, fire_q, unused_dir;
  assign unused_dir = ^loc_flit[8:6];
  assign ch_in = {westad, eastad, southad, northad};
  assign v_in = {wvalid_i, evalid_i, svalid_i, nvalid_i};
  assign loc_ready = count_q != CW'(FIFO_DEPTH);
  assign push = loc_valid && loc_ready;
  assign free = ~v_in;
  // lowest set bit of free gives the fixed N, S, E, W priority
  assign sel = free & (~free + 4'd1);
  assign pop = (count_q != '0) && (free != '0);
  assign head = mem_q[rd_q];
  assign row = head[5:3];
  assign col = head[2:0];
  assign dir = col > NODE_COL ? 3'b000 :
               col < NODE_COL ? 3'b001 :
               row > NODE_ROW ? 3'b010 :
               row < NODE_ROW ? 3'b011 : 3'b100;
  assign inj_flit = {head[7:6], dir, head[5:0]};
  assign count_d = count_q + CW'(push) - CW'(pop);
  assign blocked_d = (pop || count_q == '0) ? '0 :
                     (blocked_q == BW'(STARVE_LIMIT)) ? blocked_q : blocked_q + 1'b1;
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ch_d[i] = (pop && sel[i]) ? inj_flit : (v_in[i] ? ch_in[i] : 11'b0);
    end
    v_d = v_in | (pop ? sel : 4'b0);
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (count_d != '0) ? ACTIVE : IDLE;
      ACTIVE:  state_d = (count_d == '0) ? IDLE :
                         (!pop && blocked_q == BW'(STARVE_LIMIT)) ? STARVED : ACTIVE;
      STARVED: state_d = (count_d == '0) ? IDLE : pop ? ACTIVE : STARVED;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      blocked_q <= '0;
      ch_q      <= '0;
      v_q       <= '0;
      fire_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_q + AW'(push);
      rd_q      <= rd_q + AW'(pop);
      count_q   <= count_d;
      blocked_q <= blocked_d;
      ch_q      <= ch_d;
      v_q       <= v_d;
      fire_q    <= pop;
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n && push) mem_q[wr_q] <= {loc_flit[10:9], loc_flit[5:0]};
  end
  assign nad = ch_q[0];
  assign sad = ch_q[1];
  assign ead = ch_q[2];
  assign wad = ch_q[3];
  assign {wvalid_o, evalid_o, svalid_o, nvalid_o} = v_q;
  assign starve = state_q == STARVED;
  assign inj_fire = fire_q;
endmodule

// File: tb/tb_flit_injector.sv
// tb_flit_injector: randomized + directed stimulus against a queue-based reference model,
// with expected outputs scoreboarded per cycle and checked by an independent monitor.
module tb_flit_injector;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, loc_valid, loc_ready, starve, inj_fire;
  logic [10:0] loc_flit, nad, sad, ead, wad;
  logic nvo, svo, evo, wvo;
  logic [3:0][10:0] ci, od;
  logic [3:0] vi, ov;
  flit_injector dut (
    .clk(clk), .rst_n(rst_n), .loc_flit(loc_flit), .loc_valid(loc_valid), .loc_ready(loc_ready),
    .northad(ci[0]), .southad(ci[1]), .eastad(ci[2]), .westad(ci[3]),
    .nvalid_i(vi[0]), .svalid_i(vi[1]), .evalid_i(vi[2]), .wvalid_i(vi[3]),
    .nad(nad), .sad(sad), .ead(ead), .wad(wad),
    .nvalid_o(nvo), .svalid_o(svo), .evalid_o(evo), .wvalid_o(wvo),
    .starve(starve), .inj_fire(inj_fire)
  );
  assign od = {wad, ead, sad, nad};
  assign ov = {wvo, evo, svo, nvo};
  typedef struct {
    int tag;
    logic [3:0][10:0] d;
    logic [3:0] v;
    logic rdy, st, fire;
  } exp_t;
  exp_t exp_q[$];
  logic [10:0] mq[$];
  int run = 0;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  always @(posedge clk) cyc <= cyc + 1;
  // XY rule: column first, then row; node sits at (4,4)
  function automatic logic [10:0] route(input logic [10:0] f);
    int r, c;
    logic [2:0] d;
    r = int'(f[5:3]);
    c = int'(f[2:0]);
    if (c > 4) d = 3'd0;
    else if (c < 4) d = 3'd1;
    else if (r > 4) d = 3'd2;
    else if (r < 4) d = 3'd3;
    else d = 3'd4;
    return {f[10:9], d, f[5:0]};
  endfunction
  task automatic chk(input string nm, input logic [10:0] act, input logic [10:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].tag == cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("ch%0d_flit", i), od[i], e.d[i]);
        chk($sformatf("ch%0d_valid", i), 11'(ov[i]), 11'(e.v[i]));
      end
      chk("loc_ready", 11'(loc_ready), 11'(e.rdy));
      chk("starve", 11'(starve), 11'(e.st));
      chk("inj_fire", 11'(inj_fire), 11'(e.fire));
    end
  end
  task automatic drive(input bit r, input bit lv, input logic [10:0] lf,
                       input logic [3:0] v, input logic [3:0][10:0] c);
    exp_t e;
    int sz;
    bit fire, push, done;
    logic [10:0] f;
    rst_n = r; loc_valid = lv; loc_flit = lf; vi = v; ci = c;
    e.tag = cyc + 1; e.d = '0; e.v = '0; e.fire = 1'b0; e.st = 1'b0; e.rdy = 1'b1;
    if (!r) begin
      mq.delete();
      run = 0;
    end else begin
      sz = mq.size();
      push = lv && sz != DEPTH;
      fire = sz > 0 && v != 4'hf;
      done = 1'b0;
      e.v = v;
      for (int i = 0; i < 4; i++) e.d[i] = v[i] ? c[i] : 11'b0;
      if (fire) begin
        f = route(mq.pop_front());
        for (int i = 0; i < 4; i++)
          if (!v[i] && !done) begin
            e.d[i] = f; e.v[i] = 1'b1; done = 1'b1;
          end
      end
      run = (sz > 0 && v == 4'hf) ? run + 1 : 0;
      e.st = run > LIMIT;
      if (push) mq.push_back(lf);
      e.rdy = mq.size() != DEPTH;
      e.fire = fire;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  function automatic logic [3:0][10:0] rnd_ch();
    logic [3:0][10:0] c;
    for (int i = 0; i < 4; i++) c[i] = 11'($urandom);
    return c;
  endfunction
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [3:0][10:0] z, ns;
    z = '0;
    ns = {11'h000, 11'h000, 11'h456, 11'h123};
    repeat (2) drive(1'b0, 1'b1, 11'h7ff, 4'h0, z);
    drive(1'b1, 1'b0, 11'h0, 4'h0, z);
    drive(1'b1, 1'b1, 11'b00_000_110101, 4'h0, z);
    repeat (2) drive(1'b1, 1'b0, 11'h0, 4'h0, z);
    drive(1'b1, 1'b1, 11'b01_111_100100, 4'b0011, ns);
    repeat (2) drive(1'b1, 1'b0, 11'h0, 4'b0011, ns);
    drive(1'b1, 1'b1, 11'b10_000_011010, 4'hf, rnd_ch());
    repeat (12) drive(1'b1, 1'b0, 11'h0, 4'hf, rnd_ch());
    drive(1'b1, 1'b0, 11'h0, 4'b0111, rnd_ch());
    repeat (2) drive(1'b1, 1'b0, 11'h0, 4'h0, rnd_ch());
    repeat (5) drive(1'b1, 1'b1, 11'($urandom), 4'hf, rnd_ch());
    repeat (7) drive(1'b1, 1'b1, 11'($urandom), 4'h0, rnd_ch());
    repeat (3) drive(1'b1, 1'b0, 11'h0, 4'h0, rnd_ch());
    repeat (3) drive(1'b1, 1'b1, 11'($urandom), 4'hf, rnd_ch());
    repeat (10) drive(1'b1, 1'b0, 11'h0, 4'hf, rnd_ch());
    drive(1'b0, 1'b1, 11'($urandom), 4'hf, rnd_ch());
    repeat (4) drive(1'b1, 1'b0, 11'h0, 4'h0, rnd_ch());
    for (int k = 0; k < 400; k++) begin
      logic [3:0] v;
      v = (k % 40 < 12) ? 4'hf : 4'($urandom);
      drive($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, 11'($urandom), v, rnd_ch());
    end
    repeat (2) drive(1'b1, 1'b0, 11'h0, 4'h0, z);
    @(negedge clk);
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/flit_injector.md
Name: flit_injector

Overview:
- Injection stage for the bufferless deflection router node, the counterpart of the node's ejector.
- Accepts 11-bit flits {gs[1:0], dir[2:0], addr[5:0]} from the local PE into a small FIFO.
- Computes each flit's output direction with the same XY rule the ejector uses (addr[5:3]=row, addr[2:0]=col).
- Inserts one flit per cycle into the first free network channel, and registers all four channels through one pipeline stage.

Parameters:
- FIFO_DEPTH, 4, local injection queue depth in flits (power of two, ≥2).
- NODE_ROW, 3'd4, this node's row coordinate.
- NODE_COL, 3'd4, this node's column coordinate.
- STARVE_LIMIT, 8, consecutive blocked cycles before starve is asserted (≥1).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- loc_flit  input  11  flit from local PE (gs, dir ignored on input, addr).
- loc_valid  input  1  loc_flit valid.
- loc_ready  output  1  FIFO can accept; a transfer occurs when loc_valid && loc_ready at a clk edge.
- northad, southad, eastad, westad  input  11 each  incoming channel flits.
- nvalid_i, svalid_i, evalid_i, wvalid_i  input  1 each  channel occupied.
- nad, sad, ead, wad  output  11 each  registered outgoing channel flits.
- nvalid_o, svalid_o, evalid_o, wvalid_o  output  1 each  outgoing channel occupied.
- starve  output  1  injection blocked ≥ STARVE_LIMIT cycles.
- inj_fire  output  1  registered pulse, a flit was injected this cycle.

Behaviour:
- Reset (rst_n=0 at edge):
  - FIFO emptied; count=0.
  - All *ad outputs = 11'b0 and all *valid_o = 0.
  - starve=0, inj_fire=0, state=IDLE, blocked counter=0.
  - loc_ready=1 in the first cycle after reset.
  - Reset mid-operation discards all queued and in-flight flits.
- Enqueue: loc_ready = (count != FIFO_DEPTH), derived from registered count only.
  - A dequeue in the same cycle does not raise loc_ready.
  - Simultaneous enqueue and dequeue: count unchanged, order preserved.
  - Pointers wrap modulo FIFO_DEPTH.
- Route computation at dequeue, on the head flit, using row=addr[5:3], col=addr[2:0]:
  - col>NODE_COL: dir=000 (E).
  - col<NODE_COL: dir=001 (W).
  - col==NODE_COL and row>NODE_ROW: dir=010 (N).
  - col==NODE_COL and row<NODE_ROW: dir=011 (S).
  - Both equal (self-addressed): dir=100 (local); the flit is still injected and is ejected at the next ejector.
  - gs and addr are passed unchanged.
- Channel pass-through:
  - Every cycle, each *ad/*valid_o register loads its corresponding input; latency 1 cycle.
  - The flit on a channel whose valid_i=0 is don't-care and is output as 0.
- Injection:
  - When FIFO non-empty and at least one valid_i=0, the head flit (with computed dir) replaces the first free channel in fixed priority N, S, E, W.
  - That channel's valid_o=1 next cycle; head is popped; inj_fire=1 next cycle.
  - At most one injection per cycle. Occupied channels are never overwritten.
- FSM (registered):
  - IDLE: FIFO empty. Goes to ACTIVE when count becomes non-zero.
  - ACTIVE: FIFO non-empty. On each cycle with no free channel, increment blocked counter (saturating); on injection, clear it. Goes to STARVED when the counter reaches STARVE_LIMIT. Goes to IDLE when the last flit is popped and there is no enqueue.
  - STARVED: starve=1. Goes to ACTIVE (starve=0, counter cleared) on the first injection, or to IDLE if the FIFO empties.
- starve is registered, so it asserts on the cycle after the counter reaches STARVE_LIMIT.

Test Plan:
1. Reset with loc_valid=1 held → all outputs 0, loc_ready=1 next cycle, no enqueue during reset.
2. All channels free; inject 11'b00_000_110101 (row 6, col 5) → next cycle nad=11'b00_000_110101 (dir=E), nvalid_o=1, inj_fire=1, FIFO empty.
3. N, S occupied (northad=11'h123, southad=11'h456) and E free; inject addr 6'b100_100 → ead carries dir=100, while nad=11'h123 and sad=11'h456 pass through unchanged one cycle later.
4. All valid_i=1 for 10 cycles with 1 queued flit → starve rises 9 cycles after blocking begins (STARVE_LIMIT=8); freeing westad injects into wad and starve falls the next cycle.
5. Enqueue 5 flits back-to-back with channels blocked → loc_ready=0 after the 4th; unblock, then enqueue and dequeue in the same cycle → FIFO order preserved across pointer wrap.
6. Assert rst_n=0 with 3 flits queued and starve=1 → everything cleared, no stale flit appears on any output afterward.
